// File: rtl/archer_projectile_ctl.sv
// Archer projectile control: launches one arrow per click towards the cursor,
// advances it once per frame and retires it on hit, screen exit, range or stop.
module archer_projectile_ctl #(
  parameter int SPEED           = 8,
  parameter int MAX_FRAMES      = 90,
  parameter int COOLDOWN_FRAMES = 15,
  parameter int HOR_PIXELS      = 1024,
  parameter int VER_PIXELS      = 768
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        frame_tick,
  input  logic [1:0]  game_active,
  input  logic        mouse_clicked,
  input  logic [11:0] mouse_x,
  input  logic [11:0] mouse_y,
  input  logic [11:0] archer_x,
  input  logic [11:0] archer_y,
  input  logic        hit,
  output logic [11:0] pos_x_proj,
  output logic [11:0] pos_y_proj,
  output logic        projectile_active,
  output logic        projectile_animated,
  output logic        flip_hor_archer,
  output logic [2:0]  direction_sector
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    AIM  = 2'd1,
    FLY  = 2'd2,
    COOL = 2'd3
  } state_t;

  localparam int FCW = $clog2(MAX_FRAMES + 1);
  localparam int CCW = $clog2(COOLDOWN_FRAMES + 1);

  localparam logic signed [12:0] SPD   = 13'(SPEED);
  localparam logic signed [12:0] H_LIM = 13'(HOR_PIXELS);
  localparam logic signed [12:0] V_LIM = 13'(VER_PIXELS);
  localparam logic [FCW-1:0]     FRAME_LAST = FCW'(MAX_FRAMES);
  localparam logic [CCW-1:0]     COOL_LAST  = CCW'(COOLDOWN_FRAMES);

  // Quantise a (dx, dy) aim vector (dy positive = up) to one of 8 sectors;
  // the 2:1 ratio tests split the plane at roughly 26.6 degrees.
  function automatic logic [2:0] sector_of(input logic signed [12:0] dx,
                                           input logic signed [12:0] dy);
    logic [13:0] adx;
    logic [13:0] ady;
    logic [2:0]  sec;
    adx = {1'b0, (dx[12] ? -dx : dx)};
    ady = {1'b0, (dy[12] ? -dy : dy)};
    if ((ady << 1) <= adx) begin
      sec = dx[12] ? 3'd4 : 3'd0;
    end else if ((adx << 1) <= ady) begin
      sec = (!dy[12] && (dy != 13'sd0)) ? 3'd2 : 3'd6;
    end else if (!dy[12]) begin
      sec = dx[12] ? 3'd3 : 3'd1;
    end else begin
      sec = dx[12] ? 3'd5 : 3'd7;
    end
    return sec;
  endfunction

  function automatic logic signed [12:0] vel_x(input logic [2:0] sec);
    logic signed [12:0] v;
    case (sec)
      3'd0, 3'd1, 3'd7: v = SPD;
      3'd3, 3'd4, 3'd5: v = -SPD;
      default:          v = 13'sd0;
    endcase
    return v;
  endfunction

  // Screen y grows downward, so the upward sectors subtract.
  function automatic logic signed [12:0] vel_y(input logic [2:0] sec);
    logic signed [12:0] v;
    case (sec)
      3'd1, 3'd2, 3'd3: v = -SPD;
      3'd5, 3'd6, 3'd7: v = SPD;
      default:          v = 13'sd0;
    endcase
    return v;
  endfunction

  state_t             state_q, state_d;
  logic               click_q, click_d;
  logic signed [12:0] dx_q, dx_d;
  logic signed [12:0] dy_q, dy_d;
  logic signed [12:0] pos_x_q, pos_x_d;
  logic signed [12:0] pos_y_q, pos_y_d;
  logic [2:0]         sector_q, sector_d;
  logic               flip_q, flip_d;
  logic               active_q, active_d;
  logic               animated_q, animated_d;
  logic [FCW-1:0]     frame_q, frame_d;
  logic [CCW-1:0]     cool_q, cool_d;

  logic               launch;
  logic [2:0]         aim_sector;
  logic signed [12:0] next_x;
  logic signed [12:0] next_y;
  logic               out_of_range;
  logic [FCW-1:0]     frame_inc;
  logic [CCW-1:0]     cool_inc;

  always_comb begin
    launch       = mouse_clicked & ~click_q & (game_active != 2'd0) & (state_q == IDLE);
    aim_sector   = sector_of(dx_q, dy_q);
    next_x       = pos_x_q + vel_x(sector_q);
    next_y       = pos_y_q + vel_y(sector_q);
    out_of_range = next_x[12] | (next_x >= H_LIM) | next_y[12] | (next_y >= V_LIM);
    frame_inc    = frame_q + FCW'(1);
    cool_inc     = cool_q + CCW'(1);

    state_d    = state_q;
    click_d    = mouse_clicked;
    dx_d       = dx_q;
    dy_d       = dy_q;
    pos_x_d    = pos_x_q;
    pos_y_d    = pos_y_q;
    sector_d   = sector_q;
    flip_d     = flip_q;
    active_d   = active_q;
    animated_d = animated_q;
    frame_d    = frame_q;
    cool_d     = cool_q;

    case (state_q)
      IDLE: begin
        if (launch) begin
          state_d = AIM;
          dx_d    = {1'b0, mouse_x} - {1'b0, archer_x};
          dy_d    = {1'b0, archer_y} - {1'b0, mouse_y};
          pos_x_d = {1'b0, archer_x};
          pos_y_d = {1'b0, archer_y};
        end else begin
          state_d = IDLE;
        end
      end
      AIM: begin
        sector_d   = aim_sector;
        flip_d     = (aim_sector == 3'd3) || (aim_sector == 3'd4) || (aim_sector == 3'd5);
        frame_d    = '0;
        active_d   = 1'b1;
        animated_d = 1'b0;
        state_d    = FLY;
      end
      FLY: begin
        // A stop or hit wins over a same-cycle frame tick: no final move.
        if ((game_active == 2'd0) || hit) begin
          state_d    = COOL;
          active_d   = 1'b0;
          animated_d = 1'b0;
          cool_d     = '0;
        end else if (frame_tick) begin
          if (out_of_range) begin
            state_d    = COOL;
            active_d   = 1'b0;
            animated_d = 1'b0;
            cool_d     = '0;
          end else begin
            pos_x_d    = next_x;
            pos_y_d    = next_y;
            animated_d = 1'b1;
            frame_d    = frame_inc;
            if (frame_inc == FRAME_LAST) begin
              state_d    = COOL;
              active_d   = 1'b0;
              animated_d = 1'b0;
              cool_d     = '0;
            end else begin
              state_d = FLY;
            end
          end
        end else begin
          state_d = FLY;
        end
      end
      COOL: begin
        if (frame_tick) begin
          cool_d = cool_inc;
          if (cool_inc == COOL_LAST) begin
            state_d = IDLE;
          end else begin
            state_d = COOL;
          end
        end else begin
          state_d = COOL;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= IDLE;
      click_q    <= 1'b0;
      dx_q       <= '0;
      dy_q       <= '0;
      pos_x_q    <= '0;
      pos_y_q    <= '0;
      sector_q   <= 3'd0;
      flip_q     <= 1'b0;
      active_q   <= 1'b0;
      animated_q <= 1'b0;
      frame_q    <= '0;
      cool_q     <= '0;
    end else begin
      state_q    <= state_d;
      click_q    <= click_d;
      dx_q       <= dx_d;
      dy_q       <= dy_d;
      pos_x_q    <= pos_x_d;
      pos_y_q    <= pos_y_d;
      sector_q   <= sector_d;
      flip_q     <= flip_d;
      active_q   <= active_d;
      animated_q <= animated_d;
      frame_q    <= frame_d;
      cool_q     <= cool_d;
    end
  end

  assign pos_x_proj          = pos_x_q[11:0];
  assign pos_y_proj          = pos_y_q[11:0];
  assign projectile_active   = active_q;
  assign projectile_animated = animated_q;
  assign flip_hor_archer     = flip_q;
  assign direction_sector    = sector_q;

endmodule

// File: tb/tb_archer_projectile_ctl.sv
// Scoreboard bench for archer_projectile_ctl: stimulus queues cycle-stamped
// expected outputs, a negedge monitor pops and compares them.
module tb_archer_projectile_ctl;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        frame_tick = 1'b0;
  logic [1:0]  game_active = 2'd0;
  logic        mouse_clicked = 1'b0;
  logic [11:0] mouse_x = 12'd0;
  logic [11:0] mouse_y = 12'd0;
  logic [11:0] archer_x = 12'd0;
  logic [11:0] archer_y = 12'd0;
  logic        hit = 1'b0;
  logic [11:0] pos_x_proj;
  logic [11:0] pos_y_proj;
  logic        projectile_active;
  logic        projectile_animated;
  logic        flip_hor_archer;
  logic [2:0]  direction_sector;

  archer_projectile_ctl #(.MAX_FRAMES(4)) dut (
    .clk                 (clk),
    .rst                 (rst),
    .frame_tick          (frame_tick),
    .game_active         (game_active),
    .mouse_clicked       (mouse_clicked),
    .mouse_x             (mouse_x),
    .mouse_y             (mouse_y),
    .archer_x            (archer_x),
    .archer_y            (archer_y),
    .hit                 (hit),
    .pos_x_proj          (pos_x_proj),
    .pos_y_proj          (pos_y_proj),
    .projectile_active   (projectile_active),
    .projectile_animated (projectile_animated),
    .flip_hor_archer     (flip_hor_archer),
    .direction_sector    (direction_sector)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    int          cyc;
    string       nm;
    logic [11:0] x;
    logic [11:0] y;
    logic        act;
    logic        anim;
    logic        flip;
    logic [2:0]  sec;
    bit          chk_dir;
  } exp_t;

  exp_t q[$];
  int n_checks = 0;
  int n_fail   = 0;

  // Monitor: compare every expectation due in the current cycle.
  always @(negedge clk) begin
    while (q.size() > 0 && q[0].cyc <= cyc) begin
      exp_t e;
      logic ok;
      e = q.pop_front();
      n_checks++;
      ok = (e.cyc == cyc) && (pos_x_proj == e.x) && (pos_y_proj == e.y) &&
           (projectile_active == e.act) && (projectile_animated == e.anim);
      if (e.chk_dir) ok = ok && (flip_hor_archer == e.flip) && (direction_sector == e.sec);
      if (!ok) begin
        n_fail++;
        $display("FAIL %s cyc=%0d(due %0d): got x=%0d y=%0d act=%0b anim=%0b flip=%0b sec=%0d, want x=%0d y=%0d act=%0b anim=%0b flip=%0b sec=%0d",
                 e.nm, cyc, e.cyc, pos_x_proj, pos_y_proj, projectile_active, projectile_animated,
                 flip_hor_archer, direction_sector, e.x, e.y, e.act, e.anim, e.flip, e.sec);
      end
    end
  end

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic expect_at(input string nm, input int dc, input int x, input int y,
                           input bit act, input bit anim, input bit flip, input int sec,
                           input bit chk_dir);
    exp_t e;
    e.cyc = cyc + dc; e.nm = nm;
    e.x = 12'(x); e.y = 12'(y);
    e.act = act; e.anim = anim; e.flip = flip; e.sec = 3'(sec);
    e.chk_dir = chk_dir;
    q.push_back(e);
  endtask

  task automatic launch(input string nm, input int ax, input int ay, input int mx, input int my,
                        input bit flip, input int sec);
    archer_x = 12'(ax); archer_y = 12'(ay);
    mouse_x = 12'(mx);  mouse_y = 12'(my);
    mouse_clicked = 1'b1;
    expect_at({nm, "_aim"}, 1, ax, ay, 1'b0, 1'b0, 1'b0, 0, 1'b0);
    expect_at(nm, 2, ax, ay, 1'b1, 1'b0, flip, sec, 1'b1);
    step(3);
    mouse_clicked = 1'b0;
    step(1);
  endtask

  task automatic tick(input string nm, input int x, input int y, input bit act, input bit anim,
                      input bit flip, input int sec);
    frame_tick = 1'b1;
    expect_at(nm, 1, x, y, act, anim, flip, sec, 1'b1);
    step(1);
    frame_tick = 1'b0;
    step(1);
  endtask

  task automatic cool(input string nm, input int n, input int x, input int y,
                      input bit flip, input int sec);
    for (int i = 0; i < n; i++) tick(nm, x, y, 1'b0, 1'b0, flip, sec);
  endtask

  initial begin
    step(2);
    expect_at("reset", 0, 0, 0, 1'b0, 1'b0, 1'b0, 0, 1'b1);
    step(1);
    rst = 1'b0;
    game_active = 2'd1;
    step(1);

    // Launch right, three moves, then hit coinciding with a frame tick.
    launch("launch_r", 400, 300, 600, 310, 1'b0, 0);
    tick("r_t1", 408, 300, 1'b1, 1'b1, 1'b0, 0);
    tick("r_t2", 416, 300, 1'b1, 1'b1, 1'b0, 0);
    tick("r_t3", 424, 300, 1'b1, 1'b1, 1'b0, 0);
    n_checks++;
    if (pos_x_proj !== 12'd424) begin
      n_fail++;
      $display("FAIL direct_r_x: got %0d want 424", pos_x_proj);
    end
    n_checks++;
    if (direction_sector !== 3'd0) begin
      n_fail++;
      $display("FAIL direct_r_sec: got %0d want 0", direction_sector);
    end
    hit = 1'b1; frame_tick = 1'b1;
    expect_at("hit_tick", 1, 424, 300, 1'b0, 1'b0, 1'b0, 0, 1'b1);
    step(1);
    hit = 1'b0; frame_tick = 1'b0;
    step(1);
    cool("cool_r", 14, 424, 300, 1'b0, 0);
    archer_x = 12'd50; archer_y = 12'd50;
    mouse_clicked = 1'b1;
    step(3);
    expect_at("cool_click", 0, 424, 300, 1'b0, 1'b0, 1'b0, 0, 1'b1);
    mouse_clicked = 1'b0;
    step(1);
    cool("cool_r_last", 1, 424, 300, 1'b0, 0);

    // Up-left diagonal, then game stop; cooldown runs with the game stopped.
    launch("launch_ul", 400, 300, 300, 200, 1'b1, 3);
    tick("ul_t1", 392, 292, 1'b1, 1'b1, 1'b1, 3);
    n_checks++;
    if (flip_hor_archer !== 1'b1) begin
      n_fail++;
      $display("FAIL direct_ul_flip: got %0b want 1", flip_hor_archer);
    end
    n_checks++;
    if (pos_y_proj !== 12'd292) begin
      n_fail++;
      $display("FAIL direct_ul_y: got %0d want 292", pos_y_proj);
    end
    game_active = 2'd0;
    expect_at("game_stop", 1, 392, 292, 1'b0, 1'b0, 1'b1, 3, 1'b1);
    step(2);
    cool("cool_ul", 15, 392, 292, 1'b1, 3);
    archer_x = 12'd10; archer_y = 12'd10;
    mouse_clicked = 1'b1;
    step(3);
    expect_at("click_stopped", 0, 392, 292, 1'b0, 1'b0, 1'b1, 3, 1'b1);
    mouse_clicked = 1'b0;
    game_active = 2'd2;
    step(1);

    // Straight up, then plain hit.
    launch("launch_u", 400, 300, 400, 100, 1'b0, 2);
    tick("u_t1", 400, 292, 1'b1, 1'b1, 1'b0, 2);
    hit = 1'b1;
    expect_at("hit", 1, 400, 292, 1'b0, 1'b0, 1'b0, 2, 1'b1);
    step(1);
    hit = 1'b0;
    step(1);
    cool("cool_u", 15, 400, 292, 1'b0, 2);

    // Right screen edge: first move would leave the screen.
    launch("launch_edge", 1020, 300, 1023, 300, 1'b0, 0);
    tick("edge_exit", 1020, 300, 1'b0, 1'b0, 1'b0, 0);
    n_checks++;
    if (projectile_active !== 1'b0) begin
      n_fail++;
      $display("FAIL direct_edge_act: got %0b want 0", projectile_active);
    end
    n_checks++;
    if (pos_x_proj !== 12'd1020) begin
      n_fail++;
      $display("FAIL direct_edge_x: got %0d want 1020", pos_x_proj);
    end
    cool("cool_edge", 15, 1020, 300, 1'b0, 0);

    // Range limit (MAX_FRAMES=4) downward, with a re-press during flight.
    launch("launch_d", 100, 100, 100, 400, 1'b0, 6);
    tick("d_t1", 100, 108, 1'b1, 1'b1, 1'b0, 6);
    tick("d_t2", 100, 116, 1'b1, 1'b1, 1'b0, 6);
    archer_x = 12'd500; archer_y = 12'd500;
    mouse_clicked = 1'b1;
    step(2);
    expect_at("fly_click", 0, 100, 116, 1'b1, 1'b1, 1'b0, 6, 1'b1);
    tick("d_t3", 100, 124, 1'b1, 1'b1, 1'b0, 6);
    mouse_clicked = 1'b0;
    step(1);
    tick("d_range", 100, 132, 1'b0, 1'b0, 1'b0, 6);
    n_checks++;
    if (pos_y_proj !== 12'd132) begin
      n_fail++;
      $display("FAIL direct_range_y: got %0d want 132", pos_y_proj);
    end
    n_checks++;
    if (projectile_active !== 1'b0) begin
      n_fail++;
      $display("FAIL direct_range_act: got %0b want 0", projectile_active);
    end
    cool("cool_d", 15, 100, 132, 1'b0, 6);

    // Down-right diagonal, reset mid-flight.
    launch("launch_dr", 200, 200, 500, 500, 1'b0, 7);
    tick("dr_t1", 208, 208, 1'b1, 1'b1, 1'b0, 7);
    rst = 1'b1;
    expect_at("rst_mid", 1, 0, 0, 1'b0, 1'b0, 1'b0, 0, 1'b1);
    step(1);
    rst = 1'b0;
    step(1);
    expect_at("after_rst", 0, 0, 0, 1'b0, 1'b0, 1'b0, 0, 1'b1);
    step(1);

    // Zero aim vector gives sector 0.
    launch("launch_zero", 300, 300, 300, 300, 1'b0, 0);
    tick("zero_t1", 308, 300, 1'b1, 1'b1, 1'b0, 0);
    hit = 1'b1;
    expect_at("zero_hit", 1, 308, 300, 1'b0, 1'b0, 1'b0, 0, 1'b1);
    step(1);
    hit = 1'b0;
    step(1);
    cool("cool_zero", 15, 308, 300, 1'b0, 0);

    // Leftward launch.
    launch("launch_l", 500, 300, 300, 320, 1'b1, 4);
    tick("l_t1", 492, 300, 1'b1, 1'b1, 1'b1, 4);

    step(4);
    while (q.size() > 0) begin
      exp_t e;
      e = q.pop_front();
      n_checks++;
      n_fail++;
      $display("FAIL %s: expectation due cycle %0d never compared (now %0d)", e.nm, e.cyc, cyc);
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/archer_projectile_ctl.md
Name: archer_projectile_ctl

Overview:
Upstream control stage for the archer projectile renderer. On a mouse click it launches a single arrow from the archer's position towards the cursor, quantised to one of 8 direction sectors. It advances the arrow once per frame and retires it on hit, screen exit, range limit or game stop. It drives the position, active, animated, flip and sector inputs of the projectile draw stage.

Parameters:
SPEED, 8, pixels moved per frame on each non-zero axis
MAX_FRAMES, 90, flight frames before forced retirement
COOLDOWN_FRAMES, 15, frames after retirement before a new launch is accepted
HOR_PIXELS, 1024, visible width; valid x is 0..HOR_PIXELS-1
VER_PIXELS, 768, visible height; valid y is 0..VER_PIXELS-1

Ports:
clk  in  1  system clock
rst  in  1  synchronous active-high reset
frame_tick  in  1  one-cycle pulse per frame
game_active  in  2  non-zero = game running
mouse_clicked  in  1  level, high while button held
mouse_x  in  12  cursor x
mouse_y  in  12  cursor y
archer_x  in  12  archer centre x
archer_y  in  12  archer centre y
hit  in  1  collision pulse from enemy logic
pos_x_proj  out  12  arrow centre x
pos_y_proj  out  12  arrow centre y
projectile_active  out  1  arrow in flight (AIM excluded)
projectile_animated  out  1  arrow has moved at least once
flip_hor_archer  out  1  1 = flying leftwards
direction_sector  out  3  0=R,1=UR,2=U,3=UL,4=L,5=DL,6=D,7=DR

Behaviour:
- Reset (rst=1 at clk edge): state IDLE; all outputs 0; counters 0; click edge register 0. Applies mid-flight: the arrow vanishes the next cycle.
- Click edge: click_q registers mouse_clicked every cycle. launch = mouse_clicked & ~click_q & (game_active != 0) & state==IDLE. Edges in any other state are discarded, not queued.
- FSM: IDLE -> AIM -> FLY -> COOL -> IDLE.
- IDLE -> AIM on launch:
  - latch dx = mouse_x - archer_x and dy = archer_y - mouse_y, both signed 13-bit (dy positive = up).
  - latch the archer position into pos_x_proj and pos_y_proj.
- AIM, 1 cycle, sector from |dx| and |dy|:
  - 2|dy| <= |dx|: horizontal, sector 0 if dx >= 0, else 4.
  - otherwise 2|dx| <= |dy|: vertical, sector 2 if dy > 0, else 6.
  - otherwise diagonal: 1, 3, 5 or 7 by signs.
  - dx = dy = 0 gives sector 0.
  - flip_hor_archer = 1 for sectors 3, 4, 5, else 0.
  - velocity per axis is -SPEED, 0 or +SPEED by sector; screen y increases downward, so "up" subtracts.
  - frame counter cleared. Next state FLY.
- Timing: projectile_active = 1 in the cycle after AIM. That is 2 cycles after the cycle in which the launch condition is sampled true.
- FLY, per cycle, priority order:
  1. game_active == 0 or hit: go to COOL. Any same-cycle frame_tick is ignored (no move).
  2. frame_tick: compute next = pos + v in signed 13-bit.
     - next x < 0, x >= HOR_PIXELS, y < 0 or y >= VER_PIXELS: go to COOL; position not updated.
     - else update position, set projectile_animated = 1, increment frame counter.
     - counter reaching MAX_FRAMES: go to COOL after that move.
- COOL:
  - projectile_active = 0 and projectile_animated = 0.
  - pos_x_proj, pos_y_proj, flip_hor_archer and direction_sector hold their last values.
  - counts frame_ticks; after COOLDOWN_FRAMES ticks, go to IDLE.
  - game_active == 0 does not shorten the cooldown.
- Output timing and width: all outputs are registered. Position changes exactly one cycle after the qualifying frame_tick. Internal position is 13-bit signed; outputs are the low 12 bits, which are always in range.

Test Plan:
- Launch right: SPEED=8, archer (400,300), mouse (600,310), click, then 3 ticks -> active 2 cycles after the edge, sector 0, flip 0, pos (424,300), animated=1 after the 1st tick.
- Up-left: archer (400,300), mouse (300,200), 1 tick -> sector 3, flip 1, pos (392,292). Mouse (400,100) -> sector 2, pos (400,292).
- Screen exit: archer (1020,300), sector 0, 1 tick -> active=0, pos stays 1020, state COOL. After 15 ticks a new click is accepted.
- Range: MAX_FRAMES=4, sector 6 from (100,100) -> after the 4th tick pos (100,132), then active=0.
- Hit and frame_tick in the same cycle in FLY -> no move, active=0 next cycle. A click held or re-pressed during FLY or COOL -> no relaunch until IDLE and a fresh edge.
- rst asserted mid-flight -> next cycle all outputs 0; click ignored while game_active=0.
